clk_div_bank: RTL

//  Bank of N_CH independent programmable clock dividers / tick generators, driven from the single system clock.

---
 rtl/clk_div_bank_if.sv | 17 +
 rtl/clk_div_bank.sv | 132 +++++++++++++
 2 files changed

// File: rtl/clk_div_bank_if.sv
// Write port of clk_div_bank: single-slot divisor/mode update with valid/ready handshake.
interface clk_div_bank_if #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned CNT_W = 16
);
  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic             wr_valid;
  logic             wr_ready;
  logic [CH_W-1:0]  wr_ch;
  logic [CNT_W-1:0] wr_div;
  logic             wr_mode;
  logic             wr_err;

  modport master (output wr_valid, wr_ch, wr_div, wr_mode, input wr_ready, wr_err);
  modport slave  (input wr_valid, wr_ch, wr_div, wr_mode, output wr_ready, wr_err);
endinterface

// File: rtl/clk_div_bank.sv
// Bank of programmable tick/clock dividers. Writes land in a shadow slot and are committed
// at the target channel's terminal count, when it is disabled, or on sync_restart.
module clk_div_bank #(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned DEF_DIV  = 27000,
  parameter int unsigned DEF_MODE = 0
) (
  input  logic            clk,
  input  logic            rst,
  clk_div_bank_if.slave   wr,
  input  logic [N_CH-1:0] ch_en,
  input  logic            sync_restart,
  output logic [N_CH-1:0] tick,
  output logic [N_CH-1:0] slow_clk
);
  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CNT_W-1:0] DefDiv = CNT_W'(DEF_DIV);
  localparam logic DefMode = 1'(DEF_MODE);

  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];
  logic [CNT_W-1:0] div_q [N_CH];
  logic [CNT_W-1:0] div_d [N_CH];
  logic [N_CH-1:0]  mode_q, mode_d;
  logic [N_CH-1:0]  tick_q, tick_d;
  logic [N_CH-1:0]  slow_q, slow_d;

  logic             pend_q, pend_d;
  logic [CH_W-1:0]  pend_ch_q, pend_ch_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic             pend_mode_q, pend_mode_d;
  logic             wr_ready_q, wr_err_q;

  logic [2**CH_W-1:0] ch_map;
  logic               ch_ok;
  logic               accept;

  // Lookup of legal channel indices; avoids a range-limited compare when N_CH is a power of 2.
  always_comb begin
    ch_map = '0;
    for (int i = 0; i < 2**CH_W; i++) ch_map[i] = (i < int'(N_CH));
  end

  assign ch_ok  = ch_map[wr.wr_ch];
  assign accept = wr.wr_valid && wr_ready_q;

  always_comb begin
    logic term;
    logic cmt;
    term        = 1'b0;
    cmt         = 1'b0;
    cnt_d       = cnt_q;
    div_d       = div_q;
    mode_d      = mode_q;
    tick_d      = tick_q;
    slow_d      = slow_q;
    pend_d      = pend_q;
    pend_ch_d   = pend_ch_q;
    pend_div_d  = pend_div_q;
    pend_mode_d = pend_mode_q;

    if (accept && ch_ok) begin
      pend_d      = 1'b1;
      pend_ch_d   = wr.wr_ch;
      pend_div_d  = wr.wr_div;
      pend_mode_d = wr.wr_mode;
    end

    for (int i = 0; i < int'(N_CH); i++) begin
      term = (cnt_q[i] == div_q[i]);
      cmt  = pend_q && (pend_ch_q == CH_W'(i)) && (sync_restart || !ch_en[i] || term);

      if (sync_restart || !ch_en[i]) begin
        cnt_d[i]  = '0;
        tick_d[i] = 1'b0;
        slow_d[i] = 1'b0;
      end else if (term) begin
        cnt_d[i]  = '0;
        tick_d[i] = 1'b1;
        slow_d[i] = mode_q[i] ? 1'b1 : ~slow_q[i];
      end else begin
        cnt_d[i]  = cnt_q[i] + 1'b1;
        tick_d[i] = 1'b0;
        slow_d[i] = mode_q[i] ? 1'b0 : slow_q[i];
      end

      // New divisor governs the period that starts after this terminal count.
      if (cmt) begin
        div_d[i]  = pend_div_q;
        mode_d[i] = pend_mode_q;
        if (pend_mode_q != mode_q[i]) slow_d[i] = 1'b0;
        pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(N_CH); i++) begin
        cnt_q[i] <= '0;
        div_q[i] <= DefDiv;
      end
      mode_q      <= {N_CH{DefMode}};
      tick_q      <= '0;
      slow_q      <= '0;
      pend_q      <= 1'b0;
      pend_ch_q   <= '0;
      pend_div_q  <= '0;
      pend_mode_q <= 1'b0;
      wr_ready_q  <= 1'b0;
      wr_err_q    <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      mode_q      <= mode_d;
      tick_q      <= tick_d;
      slow_q      <= slow_d;
      pend_q      <= pend_d;
      pend_ch_q   <= pend_ch_d;
      pend_div_q  <= pend_div_d;
      pend_mode_q <= pend_mode_d;
      wr_ready_q  <= ~pend_d;
      wr_err_q    <= accept && !ch_ok;
    end
  end

  assign tick        = tick_q;
  assign slow_clk    = slow_q;
  assign wr.wr_ready = wr_ready_q;
  assign wr.wr_err   = wr_err_q;
endmodule
